// File: rtl/spi_op_encoder_tx.sv
// SPI master transmitter for op-tagged 3-byte frames {op, hi, lo}.
// Ports: clk, reset (sync, active high); {kbd,mouse,mic}_{req,data,ack}
//   payload handshakes; sck/cs_n/mosi SPI mode 0 MSB-first; busy = not idle.
module spi_op_encoder_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kbd_req,
  input  logic [15:0] kbd_data,
  output logic        kbd_ack,
  input  logic        mouse_req,
  input  logic [15:0] mouse_data,
  output logic        mouse_ack,
  input  logic        mic_req,
  input  logic [15:0] mic_data,
  output logic        mic_ack,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    TAIL,
    GAP
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  localparam logic [7:0] OP_KBD   = 8'h01;
  localparam logic [7:0] OP_MOUSE = 8'h02;
  localparam logic [7:0] OP_MIC   = 8'h03;

  state_t state, state_d;

  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   frame_q, frame_d;

  logic sck_d, cs_n_d, mosi_d;
  logic kbd_ack_d, mouse_ack_d, mic_ack_d;

  logic        any_req;
  logic        kbd_win, mouse_win, mic_win;
  logic [23:0] req_frame;
  logic        div_done;

  // Fixed priority: kbd > mouse > mic.
  assign any_req   = kbd_req | mouse_req | mic_req;
  assign kbd_win   = kbd_req;
  assign mouse_win = ~kbd_req & mouse_req;
  assign mic_win   = ~kbd_req & ~mouse_req & mic_req;
  assign div_done  = (div_q == DIV_LAST);

  always_comb begin
    req_frame = {OP_MIC, mic_data};
    if (kbd_win)
      req_frame = {OP_KBD, kbd_data};
    else if (mouse_win)
      req_frame = {OP_MOUSE, mouse_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      sck       <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      kbd_ack   <= 1'b0;
      mouse_ack <= 1'b0;
      mic_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      sck       <= sck_d;
      cs_n      <= cs_n_d;
      mosi      <= mosi_d;
      kbd_ack   <= kbd_ack_d;
      mouse_ack <= mouse_ack_d;
      mic_ack   <= mic_ack_d;
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_d = SHIFT_LO;
          frame_d = req_frame;
          bit_d   = 5'd23;
          div_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            state_d = SHIFT_LO;
          end else begin
            state_d = TAIL;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      TAIL: begin
        if (div_done) begin
          state_d = GAP;
          div_d   = '0;
          gap_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sck_d       = sck;
    cs_n_d      = cs_n;
    mosi_d      = mosi;
    kbd_ack_d   = 1'b0;
    mouse_ack_d = 1'b0;
    mic_ack_d   = 1'b0;
    unique case (state)
      IDLE: begin
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        if (any_req) begin
          cs_n_d      = 1'b0;
          mosi_d      = req_frame[23];
          kbd_ack_d   = kbd_win;
          mouse_ack_d = mouse_win;
          mic_ack_d   = mic_win;
        end
      end
      SHIFT_LO: begin
        if (div_done)
          sck_d = 1'b1;
      end
      SHIFT_HI: begin
        if (div_done) begin
          sck_d = 1'b0;
          // Next bit launches on the falling edge.
          if (bit_q != 5'd0)
            mosi_d = frame_q[bit_q - 5'd1];
        end
      end
      TAIL: begin
        if (div_done) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      GAP: begin
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
      end
      default: begin
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_op_encoder_tx.sv
// Bench for spi_op_encoder_tx: random payloads and request mixes checked
// against a priority/frame model and an SPI line monitor.
module tb_spi_op_encoder_tx;

  localparam int G0 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        kbd_req = 1'b0, mouse_req = 1'b0, mic_req = 1'b0;
  logic [15:0] kbd_data = '0, mouse_data = '0, mic_data = '0;
  logic        kbd_ack, mouse_ack, mic_ack;
  logic        sck, cs_n, mosi, busy;

  logic        r1 = 1'b1;
  logic        k1_req = 1'b0, m1_req = 1'b0, c1_req = 1'b0;
  logic [15:0] k1_data = '0, m1_data = '0, c1_data = '0;
  logic        k1_ack, m1_ack, c1_ack;
  logic        s1_sck, s1_cs_n, s1_mosi, s1_busy;

  int tests_run = 0;
  int failed = 0;

  spi_op_encoder_tx #(.CLK_DIV(4), .GAP_CYCLES(G0)) dut (
    .clk(clk), .reset(reset),
    .kbd_req(kbd_req), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
    .mouse_req(mouse_req), .mouse_data(mouse_data), .mouse_ack(mouse_ack),
    .mic_req(mic_req), .mic_data(mic_data), .mic_ack(mic_ack),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .busy(busy)
  );

  spi_op_encoder_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(r1),
    .kbd_req(k1_req), .kbd_data(k1_data), .kbd_ack(k1_ack),
    .mouse_req(m1_req), .mouse_data(m1_data), .mouse_ack(m1_ack),
    .mic_req(c1_req), .mic_data(c1_data), .mic_ack(c1_ack),
    .sck(s1_sck), .cs_n(s1_cs_n), .mosi(s1_mosi), .busy(s1_busy)
  );

  // Line monitor for dut
  logic [23:0] got_f[$];
  int          got_low[$];
  int          got_nb[$];
  int          got_gap[$];
  logic [23:0] shreg = '0;
  int nb = 0, low_cnt = 0, high_cnt = 0;
  int n_ack_k = 0, n_ack_m = 0, n_ack_c = 0;
  int inv_err = 0, busy_err = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;
  logic after_rst = 1'b1;

  always @(negedge clk) begin
    if (kbd_ack) n_ack_k++;
    if (mouse_ack) n_ack_m++;
    if (mic_ack) n_ack_c++;
    if (reset) after_rst = 1'b1;
    if (cs_n && (sck || mosi)) inv_err++;
    if (!cs_n && !busy) busy_err++;
    if (!cs_n) begin
      if (prev_cs) begin
        got_gap.push_back(high_cnt);
        shreg = '0;
        nb = 0;
        low_cnt = 0;
        after_rst = 1'b0;
      end
      low_cnt++;
      if (sck && !prev_sck) begin
        shreg = {shreg[22:0], mosi};
        nb++;
      end
    end else begin
      if (!prev_cs) begin
        got_f.push_back(shreg);
        got_low.push_back(low_cnt);
        got_nb.push_back(nb);
        high_cnt = 0;
      end
      if (!after_rst && high_cnt < G0 && !busy) busy_err++;
      high_cnt++;
    end
    prev_sck = sck;
    prev_cs = cs_n;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_f.delete();
    got_low.delete();
    got_nb.delete();
    got_gap.delete();
    n_ack_k = 0;
    n_ack_m = 0;
    n_ack_c = 0;
  endtask

  // Steps until n frames completed; sources drop req on their ack.
  task automatic run_frames(input int n, input int budget);
    int c;
    c = 0;
    while (got_f.size() < n && c < budget) begin
      step();
      if (kbd_ack) kbd_req = 1'b0;
      if (mouse_ack) mouse_req = 1'b0;
      if (mic_ack) mic_req = 1'b0;
      c++;
    end
    tests_run++;
    if (got_f.size() < n) begin
      failed++;
      $display("FAIL frame_timeout: got %0d frames, want %0d", got_f.size(), n);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 100) begin
      step();
      c++;
    end
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    r1 = 1'b1;
    step();
    step();
    tests_run++;
    if ({cs_n, sck, mosi, busy} !== 4'b1000) begin
      failed++;
      $display("FAIL reset_lines: cs_n,sck,mosi,busy=%b want 1000",
               {cs_n, sck, mosi, busy});
    end
    tests_run++;
    if ({kbd_ack, mouse_ack, mic_ack} !== 3'b000) begin
      failed++;
      $display("FAIL reset_acks: %b want 000", {kbd_ack, mouse_ack, mic_ack});
    end
    tests_run++;
    if ({s1_cs_n, s1_sck, s1_mosi, s1_busy} !== 4'b1000) begin
      failed++;
      $display("FAIL reset_fast: %b want 1000",
               {s1_cs_n, s1_sck, s1_mosi, s1_busy});
    end
    reset = 1'b0;
    r1 = 1'b0;
    step();
  endtask

  task automatic test_single_kbd();
    clear_mon();
    kbd_data = 16'hA55A;
    kbd_req = 1'b1;
    step();
    tests_run++;
    if (kbd_ack !== 1'b1 || cs_n !== 1'b0) begin
      failed++;
      $display("FAIL kbd_latency: ack=%b cs_n=%b want 1 0", kbd_ack, cs_n);
    end
    kbd_req = 1'b0;
    run_frames(1, 500);
    wait_idle();
    if (got_f.size() >= 1) begin
      tests_run++;
      if (got_f[0] !== 24'h01A55A) begin
        failed++;
        $display("FAIL kbd_bits: got %h want 01a55a", got_f[0]);
      end
      tests_run++;
      if (got_low[0] != 196 || got_nb[0] != 24) begin
        failed++;
        $display("FAIL kbd_timing: low=%0d edges=%0d want 196 24",
                 got_low[0], got_nb[0]);
      end
    end
    tests_run++;
    if (n_ack_k != 1) begin
      failed++;
      $display("FAIL kbd_ack_count: got %0d want 1", n_ack_k);
    end
  endtask

  task automatic test_arbitration(input logic [2:0] mask,
                                  input logic [15:0] dk,
                                  input logic [15:0] dm,
                                  input logic [15:0] dc);
    logic [23:0] exp[$];
    clear_mon();
    if (mask[0]) exp.push_back({8'h01, dk});
    if (mask[1]) exp.push_back({8'h02, dm});
    if (mask[2]) exp.push_back({8'h03, dc});
    kbd_data = dk;
    mouse_data = dm;
    mic_data = dc;
    kbd_req = mask[0];
    mouse_req = mask[1];
    mic_req = mask[2];
    run_frames(exp.size(), 2000);
    wait_idle();
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_f.size()) begin
        tests_run++;
        if (got_f[i] !== exp[i] || got_low[i] != 196 || got_nb[i] != 24) begin
          failed++;
          $display("FAIL arb_frame%0d: got %h low=%0d edges=%0d want %h 196 24",
                   i, got_f[i], got_low[i], got_nb[i], exp[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (got_gap[i] != G0 + 1) begin
            failed++;
            $display("FAIL arb_gap%0d: got %0d want %0d", i, got_gap[i], G0 + 1);
          end
        end
      end
    end
    tests_run++;
    if (n_ack_k != int'(mask[0]) || n_ack_m != int'(mask[1]) ||
        n_ack_c != int'(mask[2])) begin
      failed++;
      $display("FAIL arb_acks: got %0d%0d%0d want %b", n_ack_c, n_ack_m,
               n_ack_k, mask);
    end
  endtask

  task automatic test_mic_during_kbd();
    logic [15:0] dk, dc;
    dk = 16'($urandom);
    dc = 16'($urandom);
    clear_mon();
    kbd_data = dk;
    kbd_req = 1'b1;
    step();
    kbd_req = 1'b0;
    repeat (20) step();
    mic_data = dc;
    mic_req = 1'b1;
    run_frames(2, 1000);
    wait_idle();
    tests_run++;
    if (got_f.size() != 2 || got_f[0] !== {8'h01, dk} ||
        got_f[1] !== {8'h03, dc}) begin
      failed++;
      $display("FAIL mic_wait_frames: n=%0d want 2 frames %h %h",
               got_f.size(), {8'h01, dk}, {8'h03, dc});
    end else begin
      tests_run++;
      if (got_gap[1] != G0 + 1) begin
        failed++;
        $display("FAIL mic_wait_gap: got %0d want %0d", got_gap[1], G0 + 1);
      end
    end
    tests_run++;
    if (busy_err != 0 || n_ack_c != 1) begin
      failed++;
      $display("FAIL mic_wait_busy: busy_err=%0d mic_acks=%0d want 0 1",
               busy_err, n_ack_c);
    end
  endtask

  task automatic test_level_req();
    logic [15:0] d1, d2;
    int nk;
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    nk = 0;
    clear_mon();
    kbd_data = d1;
    kbd_req = 1'b1;
    for (int c = 0; c < 1000 && nk < 2; c++) begin
      step();
      if (kbd_ack) begin
        nk++;
        if (nk == 1) kbd_data = d2;
        else kbd_req = 1'b0;
      end
    end
    run_frames(2, 1000);
    wait_idle();
    tests_run++;
    if (got_f.size() != 2 || got_f[0] !== {8'h01, d1} ||
        got_f[1] !== {8'h01, d2} || n_ack_k != 2) begin
      failed++;
      $display("FAIL level_req: n=%0d acks=%0d want 2 frames %h %h",
               got_f.size(), n_ack_k, {8'h01, d1}, {8'h01, d2});
    end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_mon();
    mouse_data = 16'($urandom);
    mouse_req = 1'b1;
    step();
    mouse_req = 1'b0;
    c = 0;
    while (nb < 10 && c < 500) begin
      step();
      c++;
    end
    reset = 1'b1;
    step();
    tests_run++;
    if ({cs_n, sck, mosi, busy} !== 4'b1000) begin
      failed++;
      $display("FAIL mid_reset_lines: %b want 1000", {cs_n, sck, mosi, busy});
    end
    reset = 1'b0;
    repeat (300) step();
    tests_run++;
    if (n_ack_m != 1 || got_f.size() != 1 || got_nb[0] != 10) begin
      failed++;
      $display("FAIL mid_reset_drop: acks=%0d frames=%0d want 1 1",
               n_ack_m, got_f.size());
    end
    clear_mon();
    reset = 1'b1;
    kbd_req = 1'b1;
    step();
    tests_run++;
    if (kbd_ack !== 1'b0 || cs_n !== 1'b1) begin
      failed++;
      $display("FAIL reset_vs_req: ack=%b cs_n=%b want 0 1", kbd_ack, cs_n);
    end
    reset = 1'b0;
    kbd_req = 1'b0;
    repeat (5) step();
    tests_run++;
    if (n_ack_k != 0 || cs_n !== 1'b1) begin
      failed++;
      $display("FAIL reset_vs_req_after: acks=%0d cs_n=%b want 0 1",
               n_ack_k, cs_n);
    end
  endtask

  task automatic test_idle();
    int viol;
    viol = 0;
    clear_mon();
    for (int c = 0; c < 1000; c++) begin
      step();
      if ({cs_n, sck, mosi, busy, kbd_ack, mouse_ack, mic_ack} !== 7'b1000000)
        viol++;
    end
    tests_run++;
    if (viol != 0) begin
      failed++;
      $display("FAIL idle_quiet: %0d bad cycles want 0", viol);
    end
  endtask

  task automatic test_fast();
    int low, hi, gap, acks, sckerr, frames, nbit;
    logic [23:0] sh;
    logic ps, pc;
    low = 0; hi = 0; gap = 0; acks = 0; sckerr = 0; frames = 0; nbit = 0;
    sh = '0;
    ps = 1'b0;
    pc = 1'b1;
    m1_data = 16'h00FF;
    m1_req = 1'b1;
    for (int c = 0; c < 400 && frames < 2; c++) begin
      step();
      if (m1_ack) begin
        acks++;
        if (acks == 2) m1_req = 1'b0;
      end
      if (!s1_cs_n) begin
        if (pc) begin
          if (frames == 1) gap = hi;
          low = 0;
          nbit = 0;
          sh = '0;
        end
        if (low < 48) begin
          if (s1_sck !== low[0]) sckerr++;
        end else if (s1_sck !== 1'b0) sckerr++;
        if (s1_sck && !ps) begin
          sh = {sh[22:0], s1_mosi};
          nbit++;
        end
        low++;
      end else begin
        if (!pc) begin
          frames++;
          tests_run++;
          if (low != 49 || nbit != 24 || sh !== 24'h0200FF) begin
            failed++;
            $display("FAIL fast_frame%0d: low=%0d edges=%0d bits=%h want 49 24 0200ff",
                     frames, low, nbit, sh);
          end
          hi = 0;
        end
        hi++;
      end
      ps = s1_sck;
      pc = s1_cs_n;
    end
    m1_req = 1'b0;
    tests_run++;
    if (frames != 2 || gap != 2 || sckerr != 0) begin
      failed++;
      $display("FAIL fast_timing: frames=%0d gap=%0d sck_err=%0d want 2 2 0",
               frames, gap, sckerr);
    end
  endtask

  initial begin
    logic [2:0] m;
    test_reset();
    test_single_kbd();
    wait_idle();
    test_arbitration(3'b111, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 5; i++) begin
      m = 3'($urandom_range(1, 7));
      test_arbitration(m, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    test_mic_during_kbd();
    test_level_req();
    test_reset_mid();
    test_idle();
    test_fast();
    tests_run++;
    if (inv_err != 0) begin
      failed++;
      $display("FAIL idle_lines_low: %0d cycles with sck/mosi high while cs_n=1",
               inv_err);
    end
    tests_run++;
    if (busy_err != 0) begin
      failed++;
      $display("FAIL busy_track: %0d cycles with busy low in frame/gap", busy_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/spi_op_encoder_tx.md
Name: spi_op_encoder_tx

Overview:
- SPI transmit side of the op-tagged frame protocol: the opposite end of the receiver that classifies frames by op byte into keyboard, mouse and mic data.
- Accepts 16-bit payloads from three sources and arbitrates between them.
- Builds each 3-byte frame as {op[7:0], payload[15:8], payload[7:0]} and serialises it as SPI master, mode 0, MSB first.
- Op codes match the decoder: 8'h01 keyboard, 8'h02 mouse, 8'h03 mic.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period (≥1).
- GAP_CYCLES, 8, clk cycles cs_n held high after a frame before the next request is sampled (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- kbd_req  in  1  keyboard payload pending.
- kbd_data  in  16  keyboard payload; stable while kbd_req is high.
- kbd_ack  out  1  one-cycle pulse: keyboard payload accepted.
- mouse_req  in  1  mouse payload pending.
- mouse_data  in  16  mouse payload.
- mouse_ack  out  1  one-cycle accept pulse.
- mic_req  in  1  mic payload pending.
- mic_data  in  16  mic payload.
- mic_ack  out  1  one-cycle accept pulse.
- sck  out  1  SPI clock, idle low.
- cs_n  out  1  frame select, active low.
- mosi  out  1  serial data.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (all outputs registered): sck=0, cs_n=1, mosi=0, all acks=0, busy=0, state=IDLE, bit counter=0, divider=0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, TAIL, GAP.
- IDLE: requests are sampled every cycle.
  - Fixed priority: kbd > mouse > mic.
  - On a cycle with any req high, at the next edge:
    - latch the 24-bit frame in the shift register;
    - pulse the winner's ack for exactly one cycle;
    - drive cs_n=0 and mosi=frame[23];
    - set bit counter=23; go to SHIFT_LO.
  - Latency from req high (in IDLE) to ack/cs_n low is one cycle.
  - Losers' reqs are ignored this frame and remain pending.
- SHIFT_LO: sck=0 for CLK_DIV cycles, then go to SHIFT_HI with sck=1 (slave samples on this rising edge).
- SHIFT_HI: sck=1 for CLK_DIV cycles, then:
  - if bit counter>0: decrement, sck=0, mosi=next bit (changes on falling edge), go to SHIFT_LO;
  - else: sck=0, go to TAIL.
- TAIL: sck=0, mosi holds bit 0 for CLK_DIV cycles, then cs_n=1, mosi=0, go to GAP.
- cs_n low time is exactly 49·CLK_DIV cycles, with exactly 24 sck rising edges per frame (default: 196 cycles).
- GAP: cs_n=1 for GAP_CYCLES cycles, then IDLE.
  - Back-to-back frames: next ack/cs_n-low arrives earliest at GAP_CYCLES+1 cycles after cs_n rises.
- Handshake:
  - A source holds req and data stable until it sees ack.
  - req is level-sensitive. A source that leaves req high after ack has the (possibly new) data sent as a further frame.
  - Reqs that change while busy have no effect until IDLE.
- mosi=0 and sck=0 whenever cs_n=1.
- Reset mid-frame: next cycle all outputs return to reset values (cs_n=1 immediately). The in-flight frame is discarded and not retransmitted, because its ack was already given.
- Reset asserted in the same cycle as a req: reset wins; no ack.
- Divider and bit counter are sized from CLK_DIV and 24 bits. No wrap beyond bit 0.

Test Plan:
- kbd_req=1, kbd_data=16'hA55A, CLK_DIV=4:
  - kbd_ack pulses once, the cycle after req;
  - mosi sampled at the 24 sck rising edges = 24'h01A55A;
  - cs_n low exactly 196 cycles.
- kbd, mouse and mic req asserted in the same cycle (data 16'h1111/16'h2222/16'h3333), held until own ack:
  - three frames 24'h011111, 24'h022222, 24'h033333 in that order;
  - one ack each;
  - cs_n high exactly GAP_CYCLES+1=9 cycles between frames.
- mic_req held while a keyboard frame is in flight: no mic_ack until after GAP; then frame 24'h03xxxx; busy high throughout both frames.
- reset pulsed at sck edge 10 of a mouse frame:
  - next cycle cs_n=1, sck=0, mosi=0, busy=0;
  - no second mouse_ack, unless mouse_req is still high after reset.
- CLK_DIV=1, GAP_CYCLES=1, mouse_data=16'h00FF:
  - cs_n low 49 cycles;
  - sck toggles every cycle;
  - bits = 24'h0200FF.
- No reqs for 1000 cycles: cs_n=1, sck=0, mosi=0, busy=0 and all acks 0 throughout.
